// File: rtl/htif_host_arb.sv
// Host-to-tile request arbiter: round-robin between the CSR and MEM host
// ports, one transaction in flight to the tile, response routed back to its
// originator, with a response timeout and a synchronized tile reset.
module htif_host_arb #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              host_reset,
   output logic              tile_reset,

   input  logic              csr_req_valid,
   output logic              csr_req_ready,
   input  logic              csr_req_rw,
   input  logic [ADDR_W-1:0] csr_req_addr,
   input  logic [DATA_W-1:0] csr_req_data,

   input  logic              mem_req_valid,
   output logic              mem_req_ready,
   input  logic              mem_req_rw,
   input  logic [ADDR_W-1:0] mem_req_addr,
   input  logic [DATA_W-1:0] mem_req_data,

   output logic              tile_req_valid,
   input  logic              tile_req_ready,
   output logic              tile_req_kind,
   output logic              tile_req_rw,
   output logic [ADDR_W-1:0] tile_req_addr,
   output logic [DATA_W-1:0] tile_req_data,

   input  logic              tile_rep_valid,
   output logic              tile_rep_ready,
   input  logic [DATA_W-1:0] tile_rep_data,

   output logic              csr_rep_valid,
   input  logic              csr_rep_ready,
   output logic [DATA_W-1:0] csr_rep_data,

   output logic              mem_rep_valid,
   input  logic              mem_rep_ready,
   output logic [DATA_W-1:0] mem_rep_data,

   output logic              timeout_err
);

   // Wait counter is at least 10 bits wide, wider if TIMEOUT needs it.
   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic KIND_CSR = 1'b0;
   localparam logic KIND_MEM = 1'b1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef struct packed {
      logic              kind;
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             sync_q1;
   logic             sync_q2;
   logic             last_grant;
   req_t             req_q;
   logic [DATA_W-1:0] rep_data_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             grant_csr;
   logic             grant_mem;
   logic             wait_hit;
   logic             rep_taken;

   // Two-flop synchronizer for the host-requested tile reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= host_reset;
         sync_q2 <= sync_q1;
      end
   end

   assign tile_reset = rst | sync_q2;

   // Round-robin grant: on a tie the requester not served last wins.
   always_comb begin
      grant_csr = 1'b0;
      grant_mem = 1'b0;
      if (state == ST_IDLE && !tile_reset) begin
         if (csr_req_valid && mem_req_valid) begin
            if (last_grant == KIND_MEM) begin
               grant_csr = 1'b1;
            end else begin
               grant_mem = 1'b1;
            end
         end else if (csr_req_valid) begin
            grant_csr = 1'b1;
         end else if (mem_req_valid) begin
            grant_mem = 1'b1;
         end
      end
   end

   assign wait_hit  = (wait_cnt == WAIT_LAST);
   assign rep_taken = (req_q.kind == KIND_MEM) ? mem_rep_ready : csr_rep_ready;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; tile reset overrides everything and drops the transaction.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (grant_csr || grant_mem) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (tile_req_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tile_rep_valid || wait_hit) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rep_taken) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (tile_reset) begin
         state_nxt = ST_IDLE;
      end
   end

   // Request latch, response latch, wait counter, grant history and sticky timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q       <= '0;
         rep_data_q  <= '0;
         wait_cnt    <= '0;
         last_grant  <= KIND_MEM;
         timeout_err <= 1'b0;
      end else if (tile_reset) begin
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               wait_cnt <= '0;
               if (grant_csr) begin
                  req_q.kind <= KIND_CSR;
                  req_q.rw   <= csr_req_rw;
                  req_q.addr <= csr_req_addr;
                  req_q.data <= csr_req_data;
                  last_grant <= KIND_CSR;
               end else if (grant_mem) begin
                  req_q.kind <= KIND_MEM;
                  req_q.rw   <= mem_req_rw;
                  req_q.addr <= mem_req_addr;
                  req_q.data <= mem_req_data;
                  last_grant <= KIND_MEM;
               end
            end
            ST_WAIT: begin
               if (tile_rep_valid) begin
                  rep_data_q <= tile_rep_data;
                  wait_cnt   <= '0;
               end else if (wait_hit) begin
                  rep_data_q  <= '1;
                  timeout_err <= 1'b1;
                  wait_cnt    <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: wait_cnt <= '0;
         endcase
      end
   end

   // Handshake outputs decode the state register and are silenced by tile reset.
   assign csr_req_ready  = grant_csr;
   assign mem_req_ready  = grant_mem;
   assign tile_req_valid = (state == ST_ISSUE) && !tile_reset;
   assign tile_rep_ready = (state == ST_WAIT) && !tile_reset;
   assign csr_rep_valid  = (state == ST_RESP) && (req_q.kind == KIND_CSR) && !tile_reset;
   assign mem_rep_valid  = (state == ST_RESP) && (req_q.kind == KIND_MEM) && !tile_reset;

   assign tile_req_kind = req_q.kind;
   assign tile_req_rw   = req_q.rw;
   assign tile_req_addr = req_q.addr;
   assign tile_req_data = req_q.data;
   assign csr_rep_data  = rep_data_q;
   assign mem_rep_data  = rep_data_q;

endmodule

// File: tb/tb_htif_host_arb.sv
// Scoreboard bench for htif_host_arb: stimulus pushes expected tile requests
// and host responses into queues, a negedge monitor pops and compares them.
module tb_htif_host_arb;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 32;
   localparam int unsigned TO = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          host_reset;
   logic          tile_reset;
   logic          csr_req_valid, csr_req_ready, csr_req_rw;
   logic [AW-1:0] csr_req_addr;
   logic [DW-1:0] csr_req_data;
   logic          mem_req_valid, mem_req_ready, mem_req_rw;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_data;
   logic          tile_req_valid, tile_req_ready, tile_req_kind, tile_req_rw;
   logic [AW-1:0] tile_req_addr;
   logic [DW-1:0] tile_req_data;
   logic          tile_rep_valid, tile_rep_ready;
   logic [DW-1:0] tile_rep_data;
   logic          csr_rep_valid, csr_rep_ready;
   logic [DW-1:0] csr_rep_data;
   logic          mem_rep_valid, mem_rep_ready;
   logic [DW-1:0] mem_rep_data;
   logic          timeout_err;

   htif_host_arb #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .host_reset(host_reset), .tile_reset(tile_reset),
      .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready), .csr_req_rw(csr_req_rw),
      .csr_req_addr(csr_req_addr), .csr_req_data(csr_req_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .tile_req_valid(tile_req_valid), .tile_req_ready(tile_req_ready), .tile_req_kind(tile_req_kind),
      .tile_req_rw(tile_req_rw), .tile_req_addr(tile_req_addr), .tile_req_data(tile_req_data),
      .tile_rep_valid(tile_rep_valid), .tile_rep_ready(tile_rep_ready), .tile_rep_data(tile_rep_data),
      .csr_rep_valid(csr_rep_valid), .csr_rep_ready(csr_rep_ready), .csr_rep_data(csr_rep_data),
      .mem_rep_valid(mem_rep_valid), .mem_rep_ready(mem_rep_ready), .mem_rep_data(mem_rep_data),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          kind;
      logic          rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_tile_t;

   typedef struct {
      logic [DW-1:0] data;
      int            lat;
   } exp_rep_t;

   exp_tile_t     tile_q[$];
   exp_rep_t      csr_q[$];
   exp_rep_t      mem_q[$];
   logic [DW-1:0] tile_rsp_q[$];

   int  checks = 0;
   int  errors = 0;
   int  tile_delay = 0;
   bit  tile_mute = 1'b0;
   time csr_acc_t = 0;
   time mem_acc_t = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_bound(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic push_tile(input logic kind, input logic rw, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
      exp_tile_t e;
      e.kind = kind; e.rw = rw; e.addr = addr; e.data = data;
      tile_q.push_back(e);
   endtask

   task automatic push_rep(input logic kind, input logic [DW-1:0] data, input int lat);
      exp_rep_t e;
      e.data = data; e.lat = lat;
      if (kind) mem_q.push_back(e);
      else      csr_q.push_back(e);
   endtask

   // Tile model: answers tile_delay cycles into WAIT unless muted.
   initial begin
      int wcnt;
      wcnt = 0;
      tile_rep_valid = 1'b0;
      tile_rep_data  = '0;
      forever begin
         @(posedge clk); #1;
         tile_rep_valid = 1'b0;
         if (tile_rep_ready && !tile_mute) begin
            if (wcnt == tile_delay) begin
               tile_rep_valid = 1'b1;
               if (tile_rsp_q.size() > 0) tile_rep_data = tile_rsp_q.pop_front();
               else fail_bound("tile_rsp_queue");
            end
            wcnt++;
         end else begin
            wcnt = 0;
         end
      end
   end

   // Monitor: compare every handshake against the scoreboard queues.
   time      csr_start = 0, mem_start = 0;
   logic     csr_vd = 1'b0, mem_vd = 1'b0;
   exp_tile_t et;
   exp_rep_t  er;
   always @(negedge clk) begin
      if (!rst) begin
         if (tile_req_valid && tile_req_ready) begin
            if (tile_q.size() == 0) fail_bound("tile_req_unexpected");
            else begin
               et = tile_q.pop_front();
               chk("tile_req", 128'({tile_req_kind, tile_req_rw, tile_req_addr, tile_req_data}),
                   128'({et.kind, et.rw, et.addr, et.data}));
            end
         end
         if (csr_rep_valid && !csr_vd) csr_start = $time;
         csr_vd = csr_rep_valid;
         if (mem_rep_valid && !mem_vd) mem_start = $time;
         mem_vd = mem_rep_valid;
         if (csr_rep_valid && csr_rep_ready) begin
            if (csr_q.size() == 0) fail_bound("csr_rep_unexpected");
            else begin
               er = csr_q.pop_front();
               chk("csr_rep_data", 128'(csr_rep_data), 128'(er.data));
               if (er.lat >= 0) chk("csr_rep_latency", 128'((csr_start - csr_acc_t) / 10), 128'(er.lat));
            end
         end
         if (mem_rep_valid && mem_rep_ready) begin
            if (mem_q.size() == 0) fail_bound("mem_rep_unexpected");
            else begin
               er = mem_q.pop_front();
               chk("mem_rep_data", 128'(mem_rep_data), 128'(er.data));
               if (er.lat >= 0) chk("mem_rep_latency", 128'((mem_start - mem_acc_t) / 10), 128'(er.lat));
            end
         end
      end
   end

   task automatic csr_send(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int n;
      n = 0;
      csr_req_rw = rw; csr_req_addr = addr; csr_req_data = data; csr_req_valid = 1'b1;
      @(negedge clk);
      while (!csr_req_ready && n < 300) begin @(negedge clk); n++; end
      if (!csr_req_ready) fail_bound("csr_accept");
      else csr_acc_t = $time;
      @(posedge clk); #1;
      csr_req_valid = 1'b0;
   endtask

   task automatic mem_send(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int n;
      n = 0;
      mem_req_rw = rw; mem_req_addr = addr; mem_req_data = data; mem_req_valid = 1'b1;
      @(negedge clk);
      while (!mem_req_ready && n < 300) begin @(negedge clk); n++; end
      if (!mem_req_ready) fail_bound("mem_accept");
      else mem_acc_t = $time;
      @(posedge clk); #1;
      mem_req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((csr_q.size() + mem_q.size() + tile_q.size()) != 0 && n < 200) begin
         @(negedge clk); n++;
      end
      if ((csr_q.size() + mem_q.size() + tile_q.size()) != 0) begin
         fail_bound(name);
         csr_q.delete(); mem_q.delete(); tile_q.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] rst_patt;
      int n;
      rst = 1'b1; host_reset = 1'b0;
      csr_req_valid = 1'b1; csr_req_rw = 1'b0; csr_req_addr = '0; csr_req_data = '0;
      mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0; mem_req_data = '0;
      tile_req_ready = 1'b1; csr_rep_ready = 1'b1; mem_rep_ready = 1'b1;

      // Reset state, including a request held valid during reset.
      repeat (2) @(negedge clk);
      chk("rst_tile_reset", 128'(tile_reset), 128'(1));
      chk("rst_csr_req_ready", 128'(csr_req_ready), 128'(0));
      chk("rst_valids", 128'({tile_req_valid, tile_rep_ready, csr_rep_valid, mem_rep_valid, mem_req_ready}), 128'(0));
      chk("rst_timeout_err", 128'(timeout_err), 128'(0));
      chk("rst_latched_addr", 128'(tile_req_addr), 128'(0));
      csr_req_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_release_edge1", 128'(tile_reset), 128'(1));
      @(posedge clk); #1;
      chk("rst_release_edge2", 128'(tile_reset), 128'(0));

      // Both ports valid continuously: CSR wins the first tie, then alternate.
      push_tile(1'b0, 1'b0, 32'h0000_0100, 64'h0);
      push_tile(1'b1, 1'b1, 32'h0000_8000, 64'h0000_0000_CAFE_0001);
      push_tile(1'b0, 1'b1, 32'h0000_0104, 64'h0000_0000_0000_00C1);
      push_tile(1'b1, 1'b0, 32'h0000_8008, 64'h0);
      tile_rsp_q.push_back(64'h1111_0000_0000_0001);
      tile_rsp_q.push_back(64'h2222_0000_0000_0002);
      tile_rsp_q.push_back(64'h3333_0000_0000_0003);
      tile_rsp_q.push_back(64'h4444_0000_0000_0004);
      push_rep(1'b0, 64'h1111_0000_0000_0001, -1);
      push_rep(1'b0, 64'h3333_0000_0000_0003, -1);
      push_rep(1'b1, 64'h2222_0000_0000_0002, -1);
      push_rep(1'b1, 64'h4444_0000_0000_0004, -1);
      fork
         begin
            csr_send(1'b0, 32'h0000_0100, 64'h0);
            csr_send(1'b1, 32'h0000_0104, 64'h0000_0000_0000_00C1);
         end
         begin
            mem_send(1'b1, 32'h0000_8000, 64'h0000_0000_CAFE_0001);
            mem_send(1'b0, 32'h0000_8008, 64'h0);
         end
      join
      drain("drain_round_robin");

      // Single CSR read, tile answers one cycle late: 4 cycles accept-to-response.
      tile_delay = 1;
      push_tile(1'b0, 1'b0, 32'h0000_0780, 64'h0);
      tile_rsp_q.push_back(64'h1234);
      push_rep(1'b0, 64'h1234, 4);
      csr_send(1'b0, 32'h0000_0780, 64'h0);
      drain("drain_csr_read");

      // Zero-wait tile: minimum 3-cycle latency on a MEM write.
      tile_delay = 0;
      push_tile(1'b1, 1'b1, 32'h0000_2000, 64'h0000_0000_DEAD_BEEF);
      tile_rsp_q.push_back(64'h0000_0000_0000_00AC);
      push_rep(1'b1, 64'h0000_0000_0000_00AC, 3);
      mem_send(1'b1, 32'h0000_2000, 64'h0000_0000_DEAD_BEEF);
      drain("drain_min_latency");

      // CSR response stalled for 5 cycles with a MEM request waiting behind it.
      csr_rep_ready = 1'b0;
      push_tile(1'b0, 1'b0, 32'h0000_0300, 64'h0);
      push_tile(1'b1, 1'b0, 32'h0000_4000, 64'h0);
      tile_rsp_q.push_back(64'h5555_AAAA_5555_AAAA);
      tile_rsp_q.push_back(64'h0000_0000_0000_0077);
      push_rep(1'b0, 64'h5555_AAAA_5555_AAAA, -1);
      push_rep(1'b1, 64'h0000_0000_0000_0077, -1);
      csr_send(1'b0, 32'h0000_0300, 64'h0);
      fork
         mem_send(1'b0, 32'h0000_4000, 64'h0);
      join_none
      n = 0;
      @(negedge clk);
      while (!csr_rep_valid && n < 50) begin @(negedge clk); n++; end
      if (!csr_rep_valid) fail_bound("stall_rep_valid");
      for (int i = 0; i < 5; i++) begin
         chk("stall_csr_rep_valid", 128'(csr_rep_valid), 128'(1));
         chk("stall_csr_rep_data", 128'(csr_rep_data), 128'(64'h5555_AAAA_5555_AAAA));
         chk("stall_mem_req_ready", 128'({mem_req_ready, tile_req_valid}), 128'(0));
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1 csr_rep_ready = 1'b1;
      drain("drain_stall");
      wait fork;

      // Tile never answers: timeout after 15 WAIT cycles, all-ones data, sticky flag.
      chk("timeout_err_pre", 128'(timeout_err), 128'(0));
      tile_mute = 1'b1;
      push_tile(1'b1, 1'b0, 32'h0000_9000, 64'h0);
      push_rep(1'b1, {DW{1'b1}}, 17);
      mem_send(1'b0, 32'h0000_9000, 64'h0);
      drain("drain_timeout");
      chk("timeout_err_set", 128'(timeout_err), 128'(1));

      // host_reset pulse while waiting: transaction dropped, tile_reset 3 cycles.
      push_tile(1'b0, 1'b0, 32'h0000_0340, 64'h0);
      csr_send(1'b0, 32'h0000_0340, 64'h0);
      n = 0;
      @(negedge clk);
      while (!tile_rep_ready && n < 20) begin @(negedge clk); n++; end
      if (!tile_rep_ready) fail_bound("host_reset_wait_state");
      @(posedge clk); #1 host_reset = 1'b1;
      rst_patt = 6'b011100;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("host_reset_pulse", 128'(tile_reset), 128'(rst_patt[i]));
         if (i == 2) chk("host_reset_gates", 128'({tile_rep_ready, csr_rep_valid}), 128'(0));
         @(posedge clk); #1;
         if (i == 2) host_reset = 1'b0;
      end
      chk("timeout_err_kept", 128'(timeout_err), 128'(1));
      tile_mute = 1'b0;
      push_tile(1'b0, 1'b1, 32'h0000_0344, 64'h0000_0000_0000_0042);
      tile_rsp_q.push_back(64'h0000_0000_0000_0099);
      push_rep(1'b0, 64'h0000_0000_0000_0099, 3);
      csr_send(1'b1, 32'h0000_0344, 64'h0000_0000_0000_0042);
      drain("drain_after_host_reset");

      // rst in ISSUE drops tile_req_valid before the next clock edge.
      tile_req_ready = 1'b0;
      csr_send(1'b1, 32'h0000_0500, 64'h0000_0000_0000_0011);
      n = 0;
      @(negedge clk);
      while (!tile_req_valid && n < 20) begin @(negedge clk); n++; end
      if (!tile_req_valid) fail_bound("issue_state");
      #2 rst = 1'b1;
      #1;
      chk("rst_async_tile_req_valid", 128'(tile_req_valid), 128'(0));
      chk("rst_async_timeout_err", 128'({tile_reset, timeout_err}), 128'(2'b10));
      @(posedge clk); #1 rst = 1'b0;
      tile_req_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst2_tile_reset_fall", 128'(tile_reset), 128'(0));

      // After rst the grant history is MEM again, so CSR wins the tie.
      push_tile(1'b0, 1'b0, 32'h0000_0600, 64'h0);
      push_tile(1'b1, 1'b0, 32'h0000_6000, 64'h0);
      tile_rsp_q.push_back(64'h0000_0000_0000_0601);
      tile_rsp_q.push_back(64'h0000_0000_0000_6001);
      push_rep(1'b0, 64'h0000_0000_0000_0601, -1);
      push_rep(1'b1, 64'h0000_0000_0000_6001, -1);
      fork
         csr_send(1'b0, 32'h0000_0600, 64'h0);
         mem_send(1'b0, 32'h0000_6000, 64'h0);
      join
      drain("drain_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/htif_host_arb.md
HTIF_HOST_ARB -- requirements
Module: htif_host_arb

Interface
REQ-001 SHALL provide parameters: DATA_W, default 64, request/response data width; ADDR_W, default 32, request address width; TIMEOUT, default 1023, maximum cycles to wait for a tile response.
REQ-002 SHALL have ports, clock and reset first: clk in 1, system clock; rst in 1, asynchronous active-high reset.
REQ-003 SHALL have host_reset in 1, host-requested tile reset; tile_reset out 1, synchronized reset to tile.
REQ-004 SHALL have csr_req_valid in 1, csr_req_ready out 1, csr_req_rw in 1 (1 = write), csr_req_addr in ADDR_W, csr_req_data in DATA_W.
REQ-005 SHALL have mem_req_valid in 1, mem_req_ready out 1, mem_req_rw in 1, mem_req_addr in ADDR_W, mem_req_data in DATA_W.
REQ-006 SHALL have tile_req_valid out 1, tile_req_ready in 1, tile_req_kind out 1 (0 = CSR, 1 = MEM), tile_req_rw out 1, tile_req_addr out ADDR_W, tile_req_data out DATA_W.
REQ-007 SHALL have tile_rep_valid in 1, tile_rep_ready out 1, tile_rep_data in DATA_W.
REQ-008 SHALL have csr_rep_valid out 1, csr_rep_ready in 1, csr_rep_data out DATA_W, plus the same three for mem_rep_*.
REQ-009 SHALL have timeout_err out 1, sticky flag, cleared only by rst.

Function
REQ-010 SHALL drive tile_reset = rst OR (host_reset delayed through two clk flops); tile_reset asserts on the 2nd rising edge after host_reset rises and deasserts on the 2nd edge after it falls.
REQ-011 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with at most one transaction outstanding.
REQ-012 IDLE: csr_req_ready / mem_req_ready SHALL be 1 only for the granted requester; on valid&ready, latch kind/rw/addr/data and go to ISSUE next cycle.
REQ-013 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it; last_grant resets to MEM so CSR wins the first tie.
REQ-014 ISSUE: tile_req_valid=1 with the latched fields held stable; on tile_req_ready go to WAIT.
REQ-015 WAIT: tile_rep_ready=1; on tile_rep_valid latch tile_rep_data and go to RESP; a 10-bit-min wait counter SHALL increment each WAIT cycle.
REQ-016 If the wait counter reaches TIMEOUT with no response, SHALL go to RESP with data = all ones and set timeout_err.
REQ-017 RESP: assert csr_rep_valid or mem_rep_valid per the latched kind, holding the data; on the matching rep_ready go to IDLE.
REQ-018 Every request, read or write, SHALL produce exactly one response to its originator.
REQ-019 tile_rep_valid outside WAIT SHALL be ignored (tile_rep_ready=0).
REQ-020 When tile_reset is 1, the FSM SHALL be forced to IDLE, all ready/valid outputs driven 0, the in-flight transaction dropped without a response, and the wait counter cleared; last_grant and timeout_err are retained.
REQ-021 Minimum latency from request acceptance to rep_valid SHALL be 3 cycles (ISSUE 1, WAIT 1, RESP) with zero-wait ready/valid on the tile side.

Reset
REQ-022 On rst assertion, asynchronously: FSM = IDLE, both sync flops = 1, tile_reset = 1, all valid/ready outputs = 0, timeout_err = 0, counter = 0, last_grant = MEM, latched data = 0.
REQ-023 After rst deasserts with host_reset = 0, tile_reset SHALL fall within 2 cycles and requests SHALL be accepted from the following cycle.

Verification
REQ-024 Single CSR read, addr 0x780, tile answers 0x1234 after 1 cycle -> csr_rep_data = 0x1234, mem_rep_valid stays 0, 4 cycles from accept to rep.
REQ-025 CSR and MEM both valid continuously for 4 transactions -> grants in order CSR, MEM, CSR, MEM, each response routed to its originator.
REQ-026 Tile never responds, TIMEOUT = 15 -> after 15 WAIT cycles, mem_rep_data = all ones, timeout_err = 1 and remaining 1 until rst.
REQ-027 host_reset pulsed for 3 cycles while in WAIT -> tile_reset high 3 cycles starting 2 edges later, no response emitted, next request processed normally.
REQ-028 csr_rep_ready held 0 for 5 cycles in RESP -> csr_rep_valid and data stable, no new request accepted until the handshake completes.
REQ-029 rst asserted mid-ISSUE -> tile_req_valid drops 0 immediately, before the next clock edge.
